// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute bundle: decoded instruction fields in, registered execute-stage fields out,
// plus flush/hold control and the stall indication back to fetch.
interface id_ex_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [18:0]      id_ctrl;
   logic [XLEN-1:0]  id_pc;
   logic [XLEN-1:0]  id_rs1_data;
   logic [XLEN-1:0]  id_rs2_data;
   logic [XLEN-1:0]  id_imm;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic             flush;
   logic             ex_hold;
   logic             ex_valid;
   logic [18:0]      ex_ctrl;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_rs1_data;
   logic [XLEN-1:0]  ex_rs2_data;
   logic [XLEN-1:0]  ex_imm;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic             stall;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, flush, ex_hold,
      input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, stall, stall_count
   );

   modport slave (
      input  id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
             id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, flush, ex_hold,
      output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, stall, stall_count
   );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection: inserts one bubble and stalls
// PC and IF/ID, honours flush (highest priority) and downstream hold.
module id_ex_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic    clk,
   input logic    rst,
   id_ex_if.slave bus
);
   // Control word is packed LSB-aligned from fun3 upward; bit 18 is a spare carried through.
   localparam int LOAD_BIT = 12;

   typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

   state_t           state_reg;
   logic             ex_valid_reg;
   logic [18:0]      ex_ctrl_reg;
   logic [XLEN-1:0]  ex_pc_reg;
   logic [XLEN-1:0]  ex_rs1_data_reg;
   logic [XLEN-1:0]  ex_rs2_data_reg;
   logic [XLEN-1:0]  ex_imm_reg;
   logic [4:0]       ex_rs1_reg;
   logic [4:0]       ex_rs2_reg;
   logic [4:0]       ex_rd_reg;
   logic [CNT_W-1:0] stall_count_reg;

   logic [4:0]       src_addr [2];
   logic [1:0]       src_used;
   logic [1:0]       src_hit;
   logic             hazard;

   assign src_addr[0] = bus.id_rs1;
   assign src_addr[1] = bus.id_rs2;
   assign src_used    = {bus.id_rs2_used, bus.id_rs1_used};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_used[gi] && (src_addr[gi] == ex_rd_reg);
      end
   endgenerate

   // A load writing x0 produces nothing to wait for.
   assign hazard = (state_reg == RUN) && ex_valid_reg && ex_ctrl_reg[LOAD_BIT] &&
                   (ex_rd_reg != 5'd0) && bus.id_valid && (|src_hit);

   assign bus.stall = bus.ex_hold | (hazard & ~bus.flush);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= RUN;
         ex_valid_reg    <= 1'b0;
         ex_ctrl_reg     <= '0;
         ex_pc_reg       <= '0;
         ex_rs1_data_reg <= '0;
         ex_rs2_data_reg <= '0;
         ex_imm_reg      <= '0;
         ex_rs1_reg      <= '0;
         ex_rs2_reg      <= '0;
         ex_rd_reg       <= '0;
         stall_count_reg <= '0;
      end else begin
         case (state_reg)
            RUN:     if (hazard && !bus.flush && !bus.ex_hold) state_reg <= BUBBLE;
            BUBBLE:  if (!bus.ex_hold) state_reg <= RUN;
            default: state_reg <= RUN;
         endcase

         if (bus.flush) begin
            ex_valid_reg <= 1'b0;
            ex_ctrl_reg  <= '0;
         end else if (bus.ex_hold) begin
            ex_valid_reg <= ex_valid_reg;
         end else if (hazard) begin
            ex_valid_reg <= 1'b0;
            ex_ctrl_reg  <= '0;
            if (stall_count_reg != {CNT_W{1'b1}})
               stall_count_reg <= stall_count_reg + CNT_W'(1);
         end else begin
            ex_valid_reg    <= bus.id_valid;
            ex_ctrl_reg     <= bus.id_valid ? bus.id_ctrl : 19'd0;
            ex_pc_reg       <= bus.id_pc;
            ex_rs1_data_reg <= bus.id_rs1_data;
            ex_rs2_data_reg <= bus.id_rs2_data;
            ex_imm_reg      <= bus.id_imm;
            ex_rs1_reg      <= bus.id_rs1;
            ex_rs2_reg      <= bus.id_rs2;
            ex_rd_reg       <= bus.id_rd;
         end
      end
   end

   assign bus.ex_valid    = ex_valid_reg;
   assign bus.ex_ctrl     = ex_ctrl_reg;
   assign bus.ex_pc       = ex_pc_reg;
   assign bus.ex_rs1_data = ex_rs1_data_reg;
   assign bus.ex_rs2_data = ex_rs2_data_reg;
   assign bus.ex_imm      = ex_imm_reg;
   assign bus.ex_rs1      = ex_rs1_reg;
   assign bus.ex_rs2      = ex_rs2_reg;
   assign bus.ex_rd       = ex_rd_reg;
   assign bus.stall_count = stall_count_reg;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, pass-through, load-use bubble, false-hazard filters,
// flush/hold priority, counter saturation and reset during a stall.
module tb_id_ex_pipe;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;   // narrow counter so saturation is reachable quickly

   localparam logic [18:0] CTRL_LW  = 19'h33102;  // reg_write, operand_b, mem_to_reg=01, Load, mem_en, fun3=010
   localparam logic [18:0] CTRL_ADD = 19'h20010;  // reg_write, alu_control=0010
   localparam logic [18:0] CTRL_LUI = 19'h34000;  // reg_write, operand_b, mem_to_reg=10

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;
   logic [CNT_W-1:0] exp_cnt;

   id_ex_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [18:0] c, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2);
      bus.id_valid    = v;
      bus.id_ctrl     = c;
      bus.id_pc       = pc;
      bus.id_rs1_data = pc + 32'h1000;
      bus.id_rs2_data = pc + 32'h2000;
      bus.id_imm      = pc + 32'h3000;
      bus.id_rs1      = rs1;
      bus.id_rs2      = rs2;
      bus.id_rd       = rd;
      bus.id_rs1_used = u1;
      bus.id_rs2_used = u2;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.flush   = 1'b0;
      bus.ex_hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 19'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
         bus.flush = 1'($urandom);
         tick();
      end
      total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0h exp 0", bus.ex_valid); else pass_cnt++;
      total_cnt++; if (bus.ex_ctrl !== 19'd0) $display("FAIL reset_ex_ctrl got %0h exp 0", bus.ex_ctrl); else pass_cnt++;
      total_cnt++; if (bus.ex_pc !== 32'd0) $display("FAIL reset_ex_pc got %0h exp 0", bus.ex_pc); else pass_cnt++;
      total_cnt++; if ({bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm} !== 96'd0) $display("FAIL reset_ex_data got %0h exp 0", {bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm}); else pass_cnt++;
      total_cnt++; if ({bus.ex_rs1, bus.ex_rs2, bus.ex_rd} !== 15'd0) $display("FAIL reset_ex_addr got %0h exp 0", {bus.ex_rs1, bus.ex_rs2, bus.ex_rd}); else pass_cnt++;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %0h exp 0", bus.stall); else pass_cnt++;
      total_cnt++; if (bus.stall_count !== 4'd0) $display("FAIL reset_count got %0h exp 0", bus.stall_count); else pass_cnt++;
      bus.flush = 1'b0;
      drive(1'b0, 19'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL release_glitch got %0h exp 0", bus.ex_valid); else pass_cnt++;
      $display("test_reset: done");
   endtask

   task automatic test_pass_through();
      drive(1'b1, CTRL_ADD, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      #1;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL pt_stall got %0h exp 0", bus.stall); else pass_cnt++;
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b1) $display("FAIL pt_ex_valid got %0h exp 1", bus.ex_valid); else pass_cnt++;
      total_cnt++; if (bus.ex_pc !== 32'h100) $display("FAIL pt_ex_pc got %0h exp 100", bus.ex_pc); else pass_cnt++;
      total_cnt++; if (bus.ex_ctrl !== CTRL_ADD) $display("FAIL pt_ex_ctrl got %0h exp %0h", bus.ex_ctrl, CTRL_ADD); else pass_cnt++;
      total_cnt++; if (bus.ex_rs1_data !== 32'h1100 || bus.ex_rs2_data !== 32'h2100 || bus.ex_imm !== 32'h3100)
         $display("FAIL pt_ex_data got %0h/%0h/%0h exp 1100/2100/3100", bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm); else pass_cnt++;
      total_cnt++; if ({bus.ex_rs1, bus.ex_rs2, bus.ex_rd} !== {5'd1, 5'd2, 5'd3}) $display("FAIL pt_ex_addr got %0h exp %0h", {bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, {5'd1, 5'd2, 5'd3}); else pass_cnt++;
      // invalid decode slot: control must be zeroed even though id_ctrl is not
      drive(1'b0, CTRL_LW, 32'h104, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 19'd0) $display("FAIL pt_invalid got v=%0h ctrl=%0h exp v=0 ctrl=0", bus.ex_valid, bus.ex_ctrl); else pass_cnt++;
      $display("test_pass_through: done");
   endtask

   task automatic test_load_use();
      // lw x5 -> add x6,x5,x1 (rs1 dependency), then lw x7 -> add x8,x1,x7 (rs2 dependency)
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, CTRL_LW, 32'h200 + 32'(k * 16), 5'd1, 5'd0, (k == 0) ? 5'd5 : 5'd7, 1'b1, 1'b0);
         tick();
         total_cnt++; if (bus.ex_ctrl !== CTRL_LW || bus.ex_valid !== 1'b1) $display("FAIL lu_load_in_ex k=%0d got v=%0h ctrl=%0h exp v=1 ctrl=%0h", k, bus.ex_valid, bus.ex_ctrl, CTRL_LW); else pass_cnt++;
         if (k == 0) drive(1'b1, CTRL_ADD, 32'h204, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1);
         else        drive(1'b1, CTRL_ADD, 32'h214, 5'd1, 5'd7, 5'd8, 1'b1, 1'b1);
         #1;
         total_cnt++; if (bus.stall !== 1'b1) $display("FAIL lu_stall k=%0d got %0h exp 1", k, bus.stall); else pass_cnt++;
         tick();
         exp_cnt = exp_cnt + 4'd1;
         total_cnt++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 19'd0) $display("FAIL lu_bubble k=%0d got v=%0h ctrl=%0h exp v=0 ctrl=0", k, bus.ex_valid, bus.ex_ctrl); else pass_cnt++;
         total_cnt++; if (bus.stall_count !== exp_cnt) $display("FAIL lu_count k=%0d got %0h exp %0h", k, bus.stall_count, exp_cnt); else pass_cnt++;
         total_cnt++; if (bus.stall !== 1'b0) $display("FAIL lu_stall_drop k=%0d got %0h exp 0", k, bus.stall); else pass_cnt++;
         tick();
         total_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== (32'h204 + 32'(k * 16)) || bus.ex_ctrl !== CTRL_ADD)
            $display("FAIL lu_dep_enters k=%0d got v=%0h pc=%0h ctrl=%0h exp v=1 pc=%0h ctrl=%0h", k, bus.ex_valid, bus.ex_pc, bus.ex_ctrl, 32'h204 + 32'(k * 16), CTRL_ADD); else pass_cnt++;
         $display("test_load_use: pair %0d count=%0d", k, bus.stall_count);
      end
   endtask

   task automatic test_no_false_hazard();
      drive(1'b1, CTRL_LW, 32'h300, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);   // lw x0
      tick();
      drive(1'b1, CTRL_ADD, 32'h304, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);  // uses x0
      #1;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL nf_x0_stall got %0h exp 0", bus.stall); else pass_cnt++;
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h304) $display("FAIL nf_x0_pass got v=%0h pc=%0h exp v=1 pc=304", bus.ex_valid, bus.ex_pc); else pass_cnt++;
      drive(1'b1, CTRL_LW, 32'h308, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);   // lw x5
      tick();
      drive(1'b1, CTRL_LUI, 32'h30c, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);  // lui x5, source fields unused
      #1;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL nf_unused_stall got %0h exp 0", bus.stall); else pass_cnt++;
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h30c || bus.ex_ctrl !== CTRL_LUI) $display("FAIL nf_unused_pass got v=%0h pc=%0h ctrl=%0h exp v=1 pc=30c ctrl=%0h", bus.ex_valid, bus.ex_pc, bus.ex_ctrl, CTRL_LUI); else pass_cnt++;
      total_cnt++; if (bus.stall_count !== exp_cnt) $display("FAIL nf_count got %0h exp %0h", bus.stall_count, exp_cnt); else pass_cnt++;
      $display("test_no_false_hazard: done");
   endtask

   task automatic test_flush();
      drive(1'b1, CTRL_LW, 32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(1'b1, CTRL_ADD, 32'h404, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1);
      bus.flush   = 1'b1;
      bus.ex_hold = 1'b1;
      #1;
      total_cnt++; if (bus.stall !== 1'b1) $display("FAIL fl_stall got %0h exp 1", bus.stall); else pass_cnt++;
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 19'd0) $display("FAIL fl_kill got v=%0h ctrl=%0h exp v=0 ctrl=0", bus.ex_valid, bus.ex_ctrl); else pass_cnt++;
      total_cnt++; if (bus.stall_count !== exp_cnt) $display("FAIL fl_count got %0h exp %0h", bus.stall_count, exp_cnt); else pass_cnt++;
      bus.ex_hold = 1'b0;
      drive(1'b1, CTRL_ADD, 32'h408, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b0) $display("FAIL fl_alone got %0h exp 0", bus.ex_valid); else pass_cnt++;
      bus.flush = 1'b0;
      $display("test_flush: done");
   endtask

   task automatic test_hold();
      drive(1'b1, CTRL_ADD, 32'h500, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      tick();
      bus.ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, CTRL_LUI, 32'h600 + 32'(i * 4), 5'd9, 5'd10, 5'd11, 1'b1, 1'b1);
         #1;
         total_cnt++; if (bus.stall !== 1'b1) $display("FAIL hd_stall i=%0d got %0h exp 1", i, bus.stall); else pass_cnt++;
         tick();
         total_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h500 || bus.ex_ctrl !== CTRL_ADD || bus.ex_rd !== 5'd3)
            $display("FAIL hd_frozen i=%0d got v=%0h pc=%0h ctrl=%0h rd=%0h exp v=1 pc=500 ctrl=%0h rd=3", i, bus.ex_valid, bus.ex_pc, bus.ex_ctrl, bus.ex_rd, CTRL_ADD); else pass_cnt++;
      end
      bus.ex_hold = 1'b0;
      // hold outranks a pending hazard: no bubble, no count until hold releases
      drive(1'b1, CTRL_LW, 32'h700, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(1'b1, CTRL_ADD, 32'h704, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1);
      bus.ex_hold = 1'b1;
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== CTRL_LW || bus.stall_count !== exp_cnt)
         $display("FAIL hd_over_hazard got v=%0h ctrl=%0h cnt=%0h exp v=1 ctrl=%0h cnt=%0h", bus.ex_valid, bus.ex_ctrl, bus.stall_count, CTRL_LW, exp_cnt); else pass_cnt++;
      bus.ex_hold = 1'b0;
      tick();
      exp_cnt = exp_cnt + 4'd1;
      total_cnt++; if (bus.ex_valid !== 1'b0 || bus.stall_count !== exp_cnt) $display("FAIL hd_then_bubble got v=%0h cnt=%0h exp v=0 cnt=%0h", bus.ex_valid, bus.stall_count, exp_cnt); else pass_cnt++;
      tick();
      $display("test_hold: done");
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, CTRL_LW, 32'h800, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
         tick();
         drive(1'b1, CTRL_ADD, 32'h804, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1);
         tick();
         if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      end
      total_cnt++; if (bus.stall_count !== 4'hF || exp_cnt !== 4'hF) $display("FAIL sat_count got %0h exp f", bus.stall_count); else pass_cnt++;
      tick();
      $display("test_saturate: count=%0d", bus.stall_count);
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, CTRL_LW, 32'h900, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(1'b1, CTRL_ADD, 32'h904, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1);
      #1;
      total_cnt++; if (bus.stall !== 1'b1) $display("FAIL rm_stall_before got %0h exp 1", bus.stall); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (bus.stall !== 1'b0 || bus.ex_valid !== 1'b0 || bus.stall_count !== 4'd0)
         $display("FAIL rm_async got stall=%0h v=%0h cnt=%0h exp 0/0/0", bus.stall, bus.ex_valid, bus.stall_count); else pass_cnt++;
      tick();
      rst = 1'b1;
      tick();
      total_cnt++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h904) $display("FAIL rm_resume got v=%0h pc=%0h exp v=1 pc=904", bus.ex_valid, bus.ex_pc); else pass_cnt++;
      $display("test_reset_mid_stall: done");
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      exp_cnt   = '0;
      test_reset();
      test_pass_through();
      test_load_use();
      test_no_false_hazard();
      test_flush();
      test_hold();
      test_saturate();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
